ps2_scan_receiver: RTL and testbench
====================================

Name: ps2_scan_receiver

Overview:
Upstream stage of regNumber. It deserialises PS/2 keyboard frames into scan-code bytes and keeps a 32-bit history of received bytes on x. It raises flag for one cycle when a break sequence (F0 followed by a code) completes. regNumber samples x when flag is high, so x = 32'h....F016 with flag = 1 means key "1" was released.

Parameters:
TIMEOUT_CYC, 50000, clk cycles without a PS/2 clock edge before a partial frame is abandoned (1 ms at 50 MHz); minimum 16.
BREAK_CODE, 8'hF0, byte that marks a key-release prefix.
SYNC_STAGES, 2, flip-flop depth of the input synchronisers; minimum 2.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
ps2_clk  in  1  raw PS/2 clock from the pin, asynchronous.
ps2_data  in  1  raw PS/2 data from the pin, asynchronous.
x  out  32  byte history; newest byte in x[7:0], older bytes shifted toward the MSBs.
flag  out  1  one-cycle pulse: a break sequence just completed.
byte_valid  out  1  one-cycle pulse: a good frame was appended to x.
frame_err  out  1  one-cycle pulse: a frame was dropped for start, parity, stop or timeout error.

Behaviour:
- Reset (async assert, sync release):
  - x = 0, flag = 0, byte_valid = 0, frame_err = 0.
  - Synchronisers preset to 1; FSM goes to IDLE; bit counter and timeout counter cleared.
  - A reset mid-frame discards the partial frame.
- Input path:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flip-flops.
  - A falling edge is a synchronised 1 -> 0 transition on ps2_clk (one extra register). Data is sampled on that edge.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data = 0 (start bit) go to DATA and clear the bit counter. An edge with data = 1 is ignored.
  - DATA: shift the sampled bits LSB-first into an 8-bit register. After the 8th bit go to PARITY.
  - PARITY: capture the bit and go to STOP.
  - STOP: on the edge, the frame is good if the stop bit = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity). Return to IDLE either way.
- Good frame, evaluated in the cycle the stop edge is detected; registered outputs visible the next cycle:
  - x <= {x[23:0], byte}; byte_valid = 1.
  - flag = 1 if the old x[7:0] == BREAK_CODE and the new byte != BREAK_CODE; otherwise 0.
- Bad frame: x unchanged, frame_err = 1, flag = 0.
- Latency: from the raw ps2_clk falling edge of the stop bit to byte_valid/flag high is SYNC_STAGES + 2 clk cycles.
- Timeout:
  - The counter runs in every state except IDLE and resets to 0 on each detected edge.
  - When it reaches TIMEOUT_CYC - 1: FSM -> IDLE, frame_err pulses, x unchanged.
  - A timeout and an edge arriving in the same cycle: the edge wins and the timeout is suppressed.
- Pulses never stretch. flag, byte_valid and frame_err are each high for exactly one cycle per event.
- flag implies byte_valid in the same cycle. frame_err and byte_valid are mutually exclusive.
- E0 extended prefixes and repeated make codes are shifted into x like any other byte; there is no special handling.
- Repeated F0 F0: the second F0 produces no flag.

Decomposition:
- Package ps2_pkg: BREAK_CODE default, state encoding (IDLE/DATA/PARITY/STOP as a 2-bit enum), and a function computing the odd-parity check.
- One natural sub-module, ps2_sync_edge: SYNC_STAGES synchronisers for both lines plus the falling-edge detector. Its outputs are data_s and fall_pulse.
- The FSM, the history shift register and the timeout counter stay in the top module.

Test Plan:
- Bench conventions: PS/2 bit period 20 clk cycles, TIMEOUT_CYC = 64 for simulation.
- Send frame 0x16 (parity 0, stop 1) after reset -> x = 32'h00000016, byte_valid pulses once, flag = 0, latency = SYNC_STAGES + 2 from the raw stop edge.
- Send 0x16, then F0, then 0x16 -> x = 32'h0016F016; flag pulses exactly once, on the last byte only; byte_valid pulses 3 times.
- Send 0x14 with parity forced to 0 -> frame_err pulses once, x unchanged, no byte_valid. Then send 0x14 correctly -> x[7:0] = 8'h14.
- Send start bit plus 4 data bits, then idle 70 cycles -> frame_err pulses at count 63, FSM is IDLE. Then a full 0x29 frame -> x[7:0] = 8'h29.
- Assert rst_n low for 3 cycles in the middle of the data bits of a frame -> all outputs 0 immediately. Then send F0, 0x14 -> x = 32'h0000F014 and flag = 1 on the 0x14 byte.
- Send F0, F0, 0x1E -> no flag on the second F0, flag on 0x1E, x = 32'h00F0F01E.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: break-code default,
// frame FSM state encoding and the odd-parity frame check.
package ps2_pkg;

  // Key-release prefix sent by PS/2 scan-code set 2 keyboards
  localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;

  // Frame position: waiting for start bit, data bits, parity bit, stop bit
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // A frame is consistent when data plus parity carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the asynchronous PS/2 clock and data pins into the clk domain and
// produces a one-cycle pulse on each falling edge of the PS/2 clock, with the
// data line registered alongside so both arrive at the FSM together.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] clk_sync_p0;
  logic [SYNC_STAGES-1:0] data_sync_p0;
  logic                   clk_prev_p1;

  // Synchroniser chains (idle-high lines, so preset to 1), then edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_p0  <= '1;
      data_sync_p0 <= '1;
      clk_prev_p1  <= 1'b1;
      fall_pulse   <= 1'b0;
      data_s       <= 1'b1;
    end else begin
      clk_sync_p0  <= {clk_sync_p0[SYNC_STAGES-2:0], ps2_clk};
      data_sync_p0 <= {data_sync_p0[SYNC_STAGES-2:0], ps2_data};
      // Stage boundary: synchronised lines -> registered edge pulse and data
      clk_prev_p1  <= clk_sync_p0[SYNC_STAGES-1];
      fall_pulse   <= clk_prev_p1 & ~clk_sync_p0[SYNC_STAGES-1];
      data_s       <= data_sync_p0[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 words into scan-code bytes,
// keeps the last four good bytes on x and pulses flag when a break sequence
// (BREAK_CODE followed by a key code) completes.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] BREAK_CODE  = BREAK_CODE_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] x,
  output logic        flag,
  output logic        byte_valid,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYC - 1);

  logic          data_s;
  logic          fall_pulse;
  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] tout_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          tout_hit;
  logic          frame_ok;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_s    (data_s),
    .fall_pulse(fall_pulse)
  );

  // A PS/2 edge in the same cycle always takes priority over the timeout
  assign tout_hit = (state != ST_IDLE) && !fall_pulse && (tout_cnt == TOUT_LAST);
  assign frame_ok = data_s && odd_parity_ok(shreg, par_bit);

  // Data bits shifted LSB-first and parity captured; no reset needed since
  // every bit is overwritten before the stop bit evaluates the frame
  always_ff @(posedge clk) begin
    if (fall_pulse && state == ST_DATA)   shreg   <= {data_s, shreg[7:1]};
    if (fall_pulse && state == ST_PARITY) par_bit <= data_s;
  end

  // Frame FSM, inactivity timeout and byte history with registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      tout_cnt   <= '0;
      x          <= '0;
      flag       <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      flag       <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (fall_pulse || state == ST_IDLE || tout_hit) tout_cnt <= '0;
      else                                            tout_cnt <= tout_cnt + TW'(1);

      if (tout_hit) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end else if (fall_pulse) begin
        unique case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: state <= ST_STOP;
          ST_STOP: begin
            state <= ST_IDLE;
            if (frame_ok) begin
              x          <= {x[23:0], shreg};
              byte_valid <= 1'b1;
              flag       <= (x[7:0] == BREAK_CODE) && (shreg != BREAK_CODE);
            end else begin
              frame_err  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Randomised bench for ps2_scan_receiver: drives PS/2 frames bit by bit and
// compares pulses, latency and the byte history against a byte-level model.
module tb_ps2_scan_receiver;

  localparam int TIMEOUT_CYC = 64;
  localparam int SYNC_STAGES = 2;
  localparam int HALF_BIT    = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] x;
  logic        flag, byte_valid, frame_err;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_fall_cyc = 0, bv_cyc = 0, err_cyc = 0;
  int bv_cnt = 0, flag_cnt = 0, err_cnt = 0, viol = 0;
  logic [31:0] xm = '0;

  ps2_scan_receiver #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .BREAK_CODE (8'hF0),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .x         (x),
    .flag      (flag),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin bv_cnt++; bv_cyc = cyc; end
      if (flag) flag_cnt++;
      if (frame_err) begin err_cnt++; err_cyc = cyc; end
      if (flag && !byte_valid) viol++;
      if (frame_err && byte_valid) viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF_BIT) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF_BIT) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
  endtask

  // Send one frame and compare against the byte-level model
  task automatic do_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    int bv0, fl0, er0;
    logic good, exp_flag;
    bv0 = bv_cnt; fl0 = flag_cnt; er0 = err_cnt;
    good = !bad_par && !bad_stop;
    exp_flag = good && (xm[7:0] == 8'hF0) && (b != 8'hF0);
    if (good) xm = {xm[23:0], b};
    send_frame(b, bad_par, bad_stop);
    repeat (15) @(negedge clk);
    chk("byte_valid_cnt", bv_cnt - bv0, {31'd0, good});
    chk("frame_err_cnt", err_cnt - er0, {31'd0, !good});
    chk("flag_cnt", flag_cnt - fl0, {31'd0, exp_flag});
    chk("x", x, xm);
    if (good) chk("latency", bv_cyc - last_fall_cyc, SYNC_STAGES + 2);
  endtask

  task automatic partial(input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_x", x, 32'h0);
    chk("rst_flag", {31'd0, flag}, 32'd0);
    chk("rst_bv", {31'd0, byte_valid}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    xm = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int er0, bv0;
    logic [7:0] b;
    int sel;

    repeat (3) @(negedge clk);
    chk("init_x", x, 32'h0);
    chk("init_pulses", {29'd0, flag, byte_valid, frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single make code
    do_frame(8'h16, 1'b0, 1'b0);
    chk("x_first", x, 32'h00000016);

    // Break sequence
    do_frame(8'hF0, 1'b0, 1'b0);
    do_frame(8'h16, 1'b0, 1'b0);
    chk("x_break", x, 32'h0016F016);

    // Parity error then a clean retry
    do_frame(8'h14, 1'b1, 1'b0);
    do_frame(8'h14, 1'b0, 1'b0);
    chk("x_retry", x[7:0], 32'h14);

    // Abandoned frame times out
    er0 = err_cnt; bv0 = bv_cnt;
    partial(4);
    repeat (70) @(negedge clk);
    chk("tout_err_cnt", err_cnt - er0, 32'd1);
    chk("tout_bv_cnt", bv_cnt - bv0, 32'd0);
    chk("tout_latency", err_cyc - last_fall_cyc, SYNC_STAGES + 2 + TIMEOUT_CYC);
    chk("tout_x", x, xm);
    do_frame(8'h29, 1'b0, 1'b0);
    chk("x_after_tout", x[7:0], 32'h29);

    // Reset mid-frame
    partial(3);
    do_reset();
    do_frame(8'hF0, 1'b0, 1'b0);
    do_frame(8'h14, 1'b0, 1'b0);
    chk("x_after_rst", x, 32'h0000F014);

    // Repeated break prefix
    do_reset();
    do_frame(8'hF0, 1'b0, 1'b0);
    do_frame(8'hF0, 1'b0, 1'b0);
    do_frame(8'h1E, 1'b0, 1'b0);
    chk("x_f0f0", x, 32'h00F0F01E);

    // Random traffic, biased toward break codes and occasional errors
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      b = (sel < 3) ? 8'hF0 : 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      do_frame(b, sel == 0, sel == 1);
    end

    chk("pulse_exclusivity", viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
